// File: rtl/fetch_unit.sv
// fetch_unit: two-stage program fetch fed by the program counter.
//   Stage 1 reads the synchronous program memory at pc_addr and latches
//   the word, its address and a valid bit. Stage 2 is the instruction
//   register. It splits the word into opcode (upper half) and operand
//   (lower half) and drives the outputs.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   enabled, pc_addr         : fetch request and address for this cycle
//   stall, flush             : hold / invalidate both stages (flush wins)
//   wr_en, wr_addr, wr_data  : program-memory write port
//   instr, oprnd, pc_out     : fetched opcode, operand and source address
//   instr_valid              : outputs hold a valid fetch
module fetch_unit #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enabled,
  input  logic [ADDR_W-1:0]   pc_addr,
  input  logic                stall,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/2-1:0] instr,
  output logic [DATA_W/2-1:0] oprnd,
  output logic [ADDR_W-1:0]   pc_out,
  output logic                instr_valid
);

  localparam int HALF = DATA_W / 2;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_s1_data;
  logic [ADDR_W-1:0] r_s1_pc;
  logic              r_s1_valid;

  // The memory has no reset, so program contents survive a pipeline reset.
  // The stage-1 read below samples the pre-edge contents. A same-cycle
  // write to the fetched address therefore returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Stage 1: memory read
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_data  <= '0;
      r_s1_pc    <= '0;
      r_s1_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (!stall) begin
      r_s1_valid <= enabled;
      if (enabled) begin
        r_s1_data <= r_mem[pc_addr];
        r_s1_pc   <= pc_addr;
      end
    end
  end

  // Stage 2: instruction register. The data fields hold whenever no new word
  // arrives, so downstream logic sees stable values while instr_valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= '0;
      oprnd       <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      instr_valid <= 1'b0;
    end else if (!stall) begin
      instr_valid <= r_s1_valid;
      if (r_s1_valid) begin
        instr  <= r_s1_data[DATA_W-1:HALF];
        oprnd  <= r_s1_data[HALF-1:0];
        pc_out <= r_s1_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0, enabled = 1'b0, stall = 1'b0, flush = 1'b0, wr_en = 1'b0;
  logic [11:0] pc_addr = '0, wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [3:0]  instr, oprnd;
  logic [11:0] pc_out;
  logic        instr_valid;

  int checks = 0, failures = 0;

  fetch_unit #(.ADDR_W(12), .DATA_W(8), .DEPTH(4096)) dut (
    .clk(clk), .reset(reset), .enabled(enabled), .pc_addr(pc_addr),
    .stall(stall), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .instr(instr), .oprnd(oprnd), .pc_out(pc_out),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  // Directed vector: inputs for one cycle and the expected outputs after its edge
  typedef struct {
    logic rst, en, stl, fl, we;
    logic [11:0] pc, wa;
    logic [7:0] wd;
    logic [3:0] ei, eo;
    logic [11:0] epc;
    logic ev;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, en, stl, fl, we, input logic [11:0] pc, wa,
                     input logic [7:0] wd, input logic [3:0] ei, eo,
                     input logic [11:0] epc, input logic ev);
    vec_t v;
    v.rst = rst; v.en = en; v.stl = stl; v.fl = fl; v.we = we;
    v.pc = pc; v.wa = wa; v.wd = wd; v.ei = ei; v.eo = eo; v.epc = epc; v.ev = ev;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string name, input int idx, input logic [3:0] ei, eo,
                     input logic [11:0] epc, input logic ev);
    checks++;
    if (instr !== ei || oprnd !== eo || pc_out !== epc || instr_valid !== ev) begin
      failures++;
      $display("FAIL %s[%0d] got i=%h o=%h pc=%h v=%b required i=%h o=%h pc=%h v=%b",
               name, idx, instr, oprnd, pc_out, instr_valid, ei, eo, epc, ev);
    end
  endtask

  // Reference model: each fetch is a transaction {valid, pc, word}. There are
  // two in-flight slots: "fetched" (read done) and "issued" (shown on outputs).
  // The program is a plain array.
  typedef struct { logic v; logic [11:0] pc; logic [7:0] w; } txn_t;
  txn_t fetched, issued;
  logic [7:0] prog [4096];

  task automatic model_cycle(input logic rst, en, stl, fl, we, input logic [11:0] pc, wa,
                             input logic [7:0] wd);
    txn_t nf, ni;
    nf = fetched; ni = issued;
    if (rst) begin
      nf = '{1'b0, 12'h0, 8'h0}; ni = '{1'b0, 12'h0, 8'h0};
    end else if (fl) begin
      nf.v = 1'b0; ni.v = 1'b0;
    end else if (!stl) begin
      if (fetched.v) ni = fetched; else ni.v = 1'b0;
      if (en) nf = '{1'b1, pc, prog[pc]}; else nf.v = 1'b0;
    end
    if (we) prog[wa] = wd;   // after the read: same-cycle read sees old word
    fetched = nf; issued = ni;
  endtask

  task automatic drive(input logic rst, en, stl, fl, we, input logic [11:0] pc, wa,
                       input logic [7:0] wd);
    reset = rst; enabled = en; stall = stl; flush = fl; wr_en = we;
    pc_addr = pc; wr_addr = wa; wr_data = wd;
  endtask

  task automatic rnd_step(input logic rst, en, stl, fl, we, input logic [11:0] pc, wa,
                          input logic [7:0] wd, input int idx);
    drive(rst, en, stl, fl, we, pc, wa, wd);
    model_cycle(rst, en, stl, fl, we, pc, wa, wd);
    @(posedge clk); #1;
    cmp("rand", idx, issued.w[7:4], issued.w[3:0], issued.pc, issued.v);
  endtask

  function automatic logic [11:0] rnd_addr();
    logic [11:0] a;
    a = 12'($urandom_range(0, 31));
    // half the pool sits just below the wrap point
    if ($urandom_range(0, 1) == 1) a = 12'hFE0 | a;
    return a;
  endfunction

  initial begin
    //   rst en stl fl we  pc      wa      wd      i     o     pc_out  v
    add(1, 0, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'h0, 4'h0, 12'h000, 0); // reset
    add(0, 0, 0, 0, 1, 12'h000, 12'h000, 8'hA5, 4'h0, 4'h0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 12'h000, 12'h001, 8'h3C, 4'h0, 4'h0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 12'h000, 12'h002, 8'hF0, 4'h0, 4'h0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 12'h000, 12'h010, 8'h11, 4'h0, 4'h0, 12'h000, 0);
    add(0, 0, 0, 0, 1, 12'h000, 12'hFFF, 8'h7E, 4'h0, 4'h0, 12'h000, 0);
    // stream 0,1,2
    add(0, 1, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'h0, 4'h0, 12'h000, 0);
    add(0, 1, 0, 0, 0, 12'h001, 12'h000, 8'h00, 4'hA, 4'h5, 12'h000, 1);
    add(0, 1, 0, 0, 0, 12'h002, 12'h000, 8'h00, 4'h3, 4'hC, 12'h001, 1);
    add(0, 0, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'hF, 4'h0, 12'h002, 1);
    add(0, 0, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'hF, 4'h0, 12'h002, 0);
    // stream with a 3-cycle stall
    add(0, 1, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'hF, 4'h0, 12'h002, 0);
    add(0, 1, 0, 0, 0, 12'h001, 12'h000, 8'h00, 4'hA, 4'h5, 12'h000, 1);
    add(0, 0, 1, 0, 0, 12'h002, 12'h000, 8'h00, 4'hA, 4'h5, 12'h000, 1);
    add(0, 0, 1, 0, 0, 12'h002, 12'h000, 8'h00, 4'hA, 4'h5, 12'h000, 1);
    add(0, 0, 1, 0, 0, 12'h002, 12'h000, 8'h00, 4'hA, 4'h5, 12'h000, 1);
    add(0, 1, 0, 0, 0, 12'h002, 12'h000, 8'h00, 4'h3, 4'hC, 12'h001, 1);
    add(0, 0, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'hF, 4'h0, 12'h002, 1);
    add(0, 0, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'hF, 4'h0, 12'h002, 0);
    // flush together with stall
    add(0, 1, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'hF, 4'h0, 12'h002, 0);
    add(0, 1, 0, 0, 0, 12'h001, 12'h000, 8'h00, 4'hA, 4'h5, 12'h000, 1);
    add(0, 0, 1, 1, 0, 12'h002, 12'h000, 8'h00, 4'hA, 4'h5, 12'h000, 0);
    add(0, 0, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'hA, 4'h5, 12'h000, 0);
    // read-during-write at 0x010
    add(0, 1, 0, 0, 1, 12'h010, 12'h010, 8'h22, 4'hA, 4'h5, 12'h000, 0);
    add(0, 0, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'h1, 4'h1, 12'h010, 1);
    add(0, 1, 0, 0, 0, 12'h010, 12'h000, 8'h00, 4'h1, 4'h1, 12'h010, 0);
    add(0, 0, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'h2, 4'h2, 12'h010, 1);
    // wraparound, then reset persistence
    add(0, 0, 0, 0, 1, 12'h000, 12'h000, 8'h81, 4'h2, 4'h2, 12'h010, 0);
    add(0, 1, 0, 0, 0, 12'hFFF, 12'h000, 8'h00, 4'h2, 4'h2, 12'h010, 0);
    add(0, 1, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'h7, 4'hE, 12'hFFF, 1);
    add(0, 0, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'h8, 4'h1, 12'h000, 1);
    add(0, 0, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'h8, 4'h1, 12'h000, 0);
    add(1, 0, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'h0, 4'h0, 12'h000, 0);
    add(0, 1, 0, 0, 0, 12'hFFF, 12'h000, 8'h00, 4'h0, 4'h0, 12'h000, 0);
    add(0, 0, 0, 0, 0, 12'h000, 12'h000, 8'h00, 4'h7, 4'hE, 12'hFFF, 1);

    @(negedge clk);
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].rst, tbl[k].en, tbl[k].stl, tbl[k].fl, tbl[k].we,
            tbl[k].pc, tbl[k].wa, tbl[k].wd);
      @(posedge clk); #1;
      cmp("vec", k, tbl[k].ei, tbl[k].eo, tbl[k].epc, tbl[k].ev);
    end

    // Hand sequence: reset asserted while a fetch is in flight. The valid bit
    // must stay low until the second enabled edge after reset deasserts.
    drive(0, 1, 0, 0, 0, 12'h001, 12'h000, 8'h00); @(posedge clk); #1;
    drive(1, 1, 0, 0, 0, 12'h002, 12'h000, 8'h00); @(posedge clk); #1;
    cmp("rst_mid", 0, 4'h0, 4'h0, 12'h000, 1'b0);
    drive(0, 1, 0, 0, 0, 12'h002, 12'h000, 8'h00); @(posedge clk); #1;
    cmp("rst_mid", 1, 4'h0, 4'h0, 12'h000, 1'b0);
    drive(0, 0, 0, 0, 0, 12'h000, 12'h000, 8'h00); @(posedge clk); #1;
    cmp("rst_mid", 2, 4'hF, 4'h0, 12'h002, 1'b1);

    // Randomized phase: reset, fill the address pool, then random traffic
    rnd_step(1, 0, 0, 0, 0, 12'h000, 12'h000, 8'h00, 0);
    for (int a = 0; a < 32; a++) begin
      rnd_step(0, 0, 0, 0, 1, 12'h000, 12'(a), 8'($urandom), a + 1);
      rnd_step(0, 0, 0, 0, 1, 12'h000, 12'hFE0 | 12'(a), 8'($urandom), a + 100);
    end
    for (int n = 0; n < 3000; n++) begin
      logic [11:0] pa, wa;
      pa = rnd_addr();
      // bias writes onto the fetched address to hit read-during-write
      wa = ($urandom_range(0, 3) == 0) ? pa : rnd_addr();
      rnd_step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 2) == 0, pa, wa, 8'($urandom), n + 1000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
